// File: rtl/regfile_burst_reader_if.sv
// Bus bundle for the register-file burst reader: single-cycle write port plus
// a valid/ready burst read request and response stream.
interface regfile_burst_reader_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] data;

    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic [AW-1:0]    req_len;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [AW-1:0]    rsp_addr;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_last;
    logic             busy;

    modport master (
        output we, waddr, data,
        output req_valid, req_addr, req_len,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, busy
    );

    modport slave (
        input  we, waddr, data,
        input  req_valid, req_addr, req_len,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, busy
    );
endinterface

// File: rtl/regfile_burst_reader.sv
// 32x32 register array with a back-pressured burst read port; every response
// field comes straight from a register so no combinational read path escapes.
module regfile_burst_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_burst_reader_if.slave   bus
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_STREAM = 1'b1;
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs_r [DEPTH];

    logic [0:0]       state_r, state_s;
    logic [AW-1:0]    len_r, len_s;
    logic [AW-1:0]    idx_r, idx_s;
    logic             rsp_valid_r, rsp_valid_s;
    logic             rsp_last_r, rsp_last_s;
    logic [AW-1:0]    rsp_addr_r, rsp_addr_s;
    logic [WIDTH-1:0] rsp_data_r, rsp_data_s;
    logic [AW-1:0]    next_addr_s;

    // Value a beat takes when loaded: a same-edge write wins over the stored
    // word, and address 0 is hard-wired to zero.
    function automatic logic [WIDTH-1:0] beat_value(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic             wr_en,
        input logic [AW-1:0]    wr_addr,
        input logic [WIDTH-1:0] wr_data
    );
        logic [WIDTH-1:0] value;
        if (addr == ADDR_ZERO) begin
            value = {WIDTH{1'b0}};
        end else if (wr_en && (wr_addr == addr)) begin
            value = wr_data;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Register array write port; entry 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (bus.we && (bus.waddr != ADDR_ZERO)) begin
            regs_r[bus.waddr] <= bus.data;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Burst FSM next-state and response-load logic.
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        idx_s       = idx_r;
        rsp_valid_s = rsp_valid_r;
        rsp_last_s  = rsp_last_r;
        rsp_addr_s  = rsp_addr_r;
        rsp_data_s  = rsp_data_r;
        next_addr_s = rsp_addr_r + ADDR_ONE;

        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_s     = ST_STREAM;
                    len_s       = bus.req_len;
                    idx_s       = ADDR_ZERO;
                    rsp_valid_s = 1'b1;
                    rsp_last_s  = (bus.req_len == ADDR_ZERO);
                    rsp_addr_s  = bus.req_addr;
                    rsp_data_s  = beat_value(bus.req_addr, regs_r[bus.req_addr],
                                             bus.we, bus.waddr, bus.data);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (rsp_valid_r && bus.rsp_ready) begin
                    if (rsp_last_r) begin
                        state_s     = ST_IDLE;
                        rsp_valid_s = 1'b0;
                        rsp_last_s  = 1'b0;
                    end else begin
                        // Address wraps modulo DEPTH through the AW-bit add.
                        idx_s       = idx_r + ADDR_ONE;
                        rsp_addr_s  = next_addr_s;
                        rsp_last_s  = ((idx_r + ADDR_ONE) == len_r);
                        rsp_data_s  = beat_value(next_addr_s, regs_r[next_addr_s],
                                                 bus.we, bus.waddr, bus.data);
                    end
                end else begin
                    state_s = ST_STREAM;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                rsp_valid_s = 1'b0;
                rsp_last_s  = 1'b0;
            end
        endcase
    end

    // FSM and response registers; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            len_r       <= ADDR_ZERO;
            idx_r       <= ADDR_ZERO;
            rsp_valid_r <= 1'b0;
            rsp_last_r  <= 1'b0;
            rsp_addr_r  <= ADDR_ZERO;
            rsp_data_r  <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            idx_r       <= idx_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_last_r  <= rsp_last_s;
            rsp_addr_r  <= rsp_addr_s;
            rsp_data_r  <= rsp_data_s;
        end
    end

    assign bus.req_ready = (state_r == ST_IDLE);
    assign bus.busy      = (state_r == ST_STREAM);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_last  = rsp_last_r;
    assign bus.rsp_addr  = rsp_addr_r;
    assign bus.rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Directed bench for regfile_burst_reader: expected beats are queued when a
// request is issued and compared as each beat is accepted.
module tb_regfile_burst_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    typedef struct packed {
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        logic             l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_burst_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus_if ();

    regfile_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    beat_t            exp_q[$];
    logic [WIDTH-1:0] model [DEPTH];
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the beat that the coming edge will accept against the scoreboard.
    task automatic consume_check();
        beat_t e;
        if (bus_if.rsp_valid === 1'b1 && bus_if.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat_valid", 32'(bus_if.rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_addr", 32'(bus_if.rsp_addr), 32'(e.a));
                chk("rsp_data", bus_if.rsp_data, e.d);
                chk("rsp_last", 32'(bus_if.rsp_last), 32'(e.l));
            end
        end
    endtask

    task automatic tick();
        consume_check();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus_if.we    = 1'b1;
        bus_if.waddr = a;
        bus_if.data  = d;
        tick();
        bus_if.we = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    task automatic push_burst(input logic [AW-1:0] a, input logic [AW-1:0] len);
        logic [AW-1:0] ad;
        for (int i = 0; i <= int'(len); i++) begin
            ad = AW'(int'(a) + i);
            exp_q.push_back('{a: ad, d: model[ad], l: (i == int'(len))});
        end
    endtask

    task automatic req(input logic [AW-1:0] a, input logic [AW-1:0] len);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = a;
        bus_if.req_len   = len;
        tick();
        bus_if.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || bus_if.rsp_valid === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_in_budget"}, 32'(n < 100), 32'd1);
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_req_ready"}, 32'(bus_if.req_ready), 32'd1);
        chk({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
        chk({tag, "_rsp_last"},  32'(bus_if.rsp_last),  32'd0);
        chk({tag, "_rsp_addr"},  32'(bus_if.rsp_addr),  32'd0);
        chk({tag, "_rsp_data"},  bus_if.rsp_data,       32'd0);
        chk({tag, "_busy"},      32'(bus_if.busy),      32'd0);
        chk({tag, "_req_ready"}, 32'(bus_if.req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        rst              = 1'b1;
        bus_if.we        = 1'b0;
        bus_if.waddr     = 5'd0;
        bus_if.data      = 32'd0;
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = 5'd0;
        bus_if.req_len   = 5'd0;
        bus_if.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst = 1'b0;
        tick();

        // Reset contents: reg 5 reads 0.
        push_burst(5'd5, 5'd0);
        req(5'd5, 5'd0);
        drain("read5");

        // Single read of a fully-set word, with one-edge latency.
        wr(5'd3, 32'hFFFF_FFFF);
        push_burst(5'd3, 5'd0);
        req(5'd3, 5'd0);
        chk("single_valid_after_accept", 32'(bus_if.rsp_valid), 32'd1);
        chk("single_busy", 32'(bus_if.busy), 32'd1);
        chk("single_req_ready", 32'(bus_if.req_ready), 32'd0);
        drain("single");

        // Wrap burst 30,31,0,1.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hA0 + 32'(i));
        push_burst(5'd30, 5'd3);
        chk("wrap_beat2_exp", exp_q[2].d, 32'd0);
        req(5'd30, 5'd3);
        drain("wrap");

        // Backpressure with rewrites of the presented address.
        bus_if.rsp_ready = 1'b0;
        push_burst(5'd10, 5'd2);
        req(5'd10, 5'd2);
        for (int k = 0; k < 3; k++) begin
            bus_if.we    = 1'b1;
            bus_if.waddr = 5'd10;
            bus_if.data  = 32'hF0F0_F0F0;
            tick();
            chk("bp_addr_frozen", 32'(bus_if.rsp_addr), 32'd10);
            chk("bp_data_frozen", bus_if.rsp_data, 32'hAA);
            chk("bp_last_frozen", 32'(bus_if.rsp_last), 32'd0);
            chk("bp_valid_held", 32'(bus_if.rsp_valid), 32'd1);
        end
        bus_if.we = 1'b0;
        model[10] = 32'hF0F0_F0F0;
        bus_if.rsp_ready = 1'b1;
        tick();
        chk("bp_next_beat_addr", 32'(bus_if.rsp_addr), 32'd11);
        drain("bp");

        // Write-through bypass on the edge that loads reg 7.
        exp_q.push_back('{a: 5'd6, d: 32'hA6, l: 1'b0});
        exp_q.push_back('{a: 5'd7, d: 32'h1234_5678, l: 1'b1});
        req(5'd6, 5'd1);
        bus_if.we    = 1'b1;
        bus_if.waddr = 5'd7;
        bus_if.data  = 32'h1234_5678;
        tick();
        bus_if.we = 1'b0;
        model[7]  = 32'h1234_5678;
        chk("bypass_data", bus_if.rsp_data, 32'h1234_5678);
        drain("bypass");

        // Register 0 ignores writes.
        wr(5'd0, 32'hFFFF_FFFF);
        exp_q.push_back('{a: 5'd0, d: 32'd0, l: 1'b1});
        req(5'd0, 5'd0);
        drain("reg0");

        // Reset mid-burst aborts and clears the array.
        push_burst(5'd0, 5'd31);
        req(5'd0, 5'd31);
        repeat (5) tick();
        chk("mid_busy_before_rst", 32'(bus_if.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("no_resume_valid", 32'(bus_if.rsp_valid), 32'd0);
        push_burst(5'd0, 5'd31);
        req(5'd0, 5'd31);
        chk("post_rst_busy", 32'(bus_if.busy), 32'd1);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
